// File: rtl/gather_arbiter.sv
// gather_arbiter: packet-locked round-robin merge of N flit streams onto one
// registered output port, with framing/length checks on a sticky error flag.
`ifndef DW
`define DW 16
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

module gather_arbiter_lane (
   input  logic       clk,
   input  logic       rstn,
   input  logic       idle,
   input  logic       sel,
   input  logic       out_free,
   input  logic       valid,
   input  logic [1:0] ftype,
   output logic       req,
   output logic       ready,
   output logic       stall_err
);
   logic orphan, orphan_q;

   assign req       = idle & valid & (ftype == `HEAD);
   assign orphan    = idle & valid & (ftype != `HEAD);
   assign ready     = sel & out_free;
   // a non-HEAD flit can never be granted; flag it on its second idle cycle
   assign stall_err = orphan & orphan_q;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) orphan_q <= 1'b0;
      else       orphan_q <= orphan;
endmodule

module gather_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N-1:0]     valid_i,
   input  logic [N*`DW-1:0] data_i,
   output logic [N-1:0]     ready_o,
   output logic             valid_o,
   output logic [`DW-1:0]   data_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic [PTR_W-1:0] grant_o,
   output logic             err_o,
   input  logic             clr_err_i
);
   typedef enum logic {IDLE, LOCK} state_t;
   localparam int CNT_W = 8;

   state_t           state, state_nxt;
   logic [PTR_W-1:0] rr_ptr, rr_nxt, grant_nxt, pick;
   logic [PTR_W:0]   idx;
   logic             found, out_free, acc, is_tail, is_head, err_set;
   logic [N-1:0]     req, stall_err;
   logic [CNT_W-1:0] flit_cnt;
   logic [`DW-1:0]   flit;
   logic [1:0]       ftype;

   assign out_free = ~valid_o | ready_i;

   for (genvar k = 0; k < N; k++) begin : g_lane
      gather_arbiter_lane u_lane (
         .clk       (clk),
         .rstn      (rstn),
         .idle      (state == IDLE),
         .sel       ((state == LOCK) && (grant_o == PTR_W'(k))),
         .out_free  (out_free),
         .valid     (valid_i[k]),
         .ftype     (data_i[k*`DW+`DW-1 -: 2]),
         .req       (req[k]),
         .ready     (ready_o[k]),
         .stall_err (stall_err[k])
      );
   end

   // walk backwards so the candidate at rr_ptr itself is written last and wins
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      idx   = '0;
      for (int i = N-1; i >= 0; i--) begin
         idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
         if (req[idx[PTR_W-1:0]]) begin
            pick  = idx[PTR_W-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      flit = '0;
      for (int k = 0; k < N; k++)
         if (grant_o == PTR_W'(k)) flit = data_i[k*`DW +: `DW];
   end

   assign acc     = |(valid_i & ready_o);
   assign ftype   = flit[`DW-1 -: 2];
   assign is_tail = (ftype == `TAIL);
   assign is_head = (ftype == `HEAD);

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state   <= IDLE;
         grant_o <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_nxt;
         grant_o <= grant_nxt;
         rr_ptr  <= rr_nxt;
      end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_o;
      rr_nxt    = rr_ptr;
      case (state)
         IDLE: if (found) begin
            state_nxt = LOCK;
            grant_nxt = pick;
         end
         LOCK: if (acc && is_tail) begin
            state_nxt = IDLE;
            rr_nxt    = (grant_o == PTR_W'(N-1)) ? '0 : grant_o + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state == LOCK);
   end

   // count is held at zero in IDLE so it starts clean on every LOCK entry
   always_ff @(posedge clk or negedge rstn)
      if (!rstn)                        flit_cnt <= '0;
      else if (state == IDLE)           flit_cnt <= '0;
      else if (acc && (flit_cnt != '1)) flit_cnt <= flit_cnt + 1'b1;

   assign err_set = (acc & is_tail & ((flit_cnt + 1'b1) != CNT_W'(`PKT_LEN)))
                  | (acc & ~is_tail & (flit_cnt >= CNT_W'(`PKT_LEN-1)))
                  | (acc & is_head & (flit_cnt != '0))
                  | (|stall_err);

   always_ff @(posedge clk or negedge rstn)
      if (!rstn)          err_o <= 1'b0;
      else if (err_set)   err_o <= 1'b1;
      else if (clr_err_i) err_o <= 1'b0;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (acc) begin
         valid_o <= 1'b1;
         data_o  <= flit;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
endmodule
